// File: rtl/mmu_ptw_gen.sv
// rtl/mmu_ptw_gen.sv - Sv32-style multi-level page table walker
//
// Walks a radix page table rooted at satp_i and returns the leaf PTE (or a
// fault) for one virtual address at a time.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   satp_i                [31] translation enable, [PPN_W-1:0] root PPN
//   req_*                 walk request (valid/ready handshake), vaddr, store flag
//   mem_*                 PTE read port: req held until ack, data/error with ack
//   resp_*                one-cycle result: pte, vpn, terminating level, fault
//   flush_i               abort the walk in progress (no response)
//   busy_o                walker not idle
//
// Optional build macro: MMU_PTW_AD_CHECK_EN - fault leaves with A=0, or D=0 on stores.
module mmu_ptw_gen #(
    parameter int LEVELS = 2,
    parameter int VPN_W  = 10,
    parameter int PPN_W  = 20,
    localparam int VA_W  = LEVELS * VPN_W + 12,
    localparam int PA_W  = PPN_W + 12
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       satp_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [VA_W-1:0]   req_vaddr_i,
    input  logic              req_store_i,
    output logic              mem_req_o,
    output logic [PA_W-1:0]   mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [31:0]       mem_data_i,
    input  logic              mem_error_i,
    output logic              resp_valid_o,
    output logic [31:0]       resp_pte_o,
    output logic [VA_W-13:0]  resp_vpn_o,
    output logic [1:0]        resp_level_o,
    output logic              resp_fault_o,
    input  logic              flush_i,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        lvl_q, lvl_d;
    logic [PA_W-1:0]   base_q, base_d;
    logic [VA_W-1:0]   vaddr_q, vaddr_d;
    logic              store_q, store_d;
    logic              abort_q, abort_d;
    logic [31:0]       pte_q, pte_d;
    logic [1:0]        rlvl_q, rlvl_d;
    logic              fault_q, fault_d;

    logic [VPN_W-1:0]  vpn_sel;
    logic [PPN_W-1:0]  pte_ppn;
    logic [PPN_W-1:0]  sp_mask;
    logic              pte_v, pte_r, pte_w, pte_x;
    logic              pte_fault, pte_leaf, misaligned, ad_fault;

    // Only some satp / PTE bits are consumed; fold the rest into a sink.
    logic              unused_bits;
    assign unused_bits = ^{satp_i, mem_data_i};

    // PTE decode and address generation
    always_comb begin
        vpn_sel    = VPN_W'(vaddr_q >> (12 + int'(lvl_q) * VPN_W));
        mem_addr_o = base_q + PA_W'({vpn_sel, 2'b00});

        pte_v      = mem_data_i[0];
        pte_r      = mem_data_i[1];
        pte_w      = mem_data_i[2];
        pte_x      = mem_data_i[3];
        pte_ppn    = mem_data_i[PPN_W+9:10];

        // A superpage leaf at level lvl must have its low lvl*VPN_W PPN bits clear.
        sp_mask = '0;
        for (int i = 0; i < PPN_W; i++) begin
            sp_mask[i] = (i < int'(lvl_q) * VPN_W);
        end

        pte_fault  = mem_error_i | ~pte_v | (pte_w & ~pte_r);
        pte_leaf   = pte_r | pte_x;
        misaligned = (lvl_q != 2'd0) && ((pte_ppn & sp_mask) != '0);
`ifdef MMU_PTW_AD_CHECK_EN
        ad_fault   = ~mem_data_i[6] | (store_q & ~mem_data_i[7]);
`else
        ad_fault   = 1'b0;
`endif
    end

    // Next-state and outputs
    always_comb begin
        state_d = state_q;
        lvl_d   = lvl_q;
        base_d  = base_q;
        vaddr_d = vaddr_q;
        store_d = store_q;
        abort_d = abort_q;
        pte_d   = pte_q;
        rlvl_d  = rlvl_q;
        fault_d = fault_q;

        req_ready_o  = (state_q == IDLE);
        mem_req_o    = (state_q == WALK);
        resp_valid_o = (state_q == DONE);
        busy_o       = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    vaddr_d = req_vaddr_i;
                    store_d = req_store_i;
                    abort_d = 1'b0;
                    lvl_d   = 2'(LEVELS - 1);
                    base_d  = {satp_i[PPN_W-1:0], 12'h000};
                    if (satp_i[31]) begin
                        state_d = WALK;
                    end else begin
                        // Translation off: answer immediately without touching memory.
                        state_d = DONE;
                        pte_d   = 32'h0;
                        rlvl_d  = 2'd0;
                        fault_d = 1'b0;
                    end
                end
            end
            WALK: begin
                if (mem_ack_i) begin
                    if (abort_q || flush_i) begin
                        // Outstanding read had to be retired before dropping the walk.
                        state_d = IDLE;
                        abort_d = 1'b0;
                    end else if (pte_fault) begin
                        state_d = DONE;
                        pte_d   = 32'h0;
                        rlvl_d  = lvl_q;
                        fault_d = 1'b1;
                    end else if (pte_leaf) begin
                        state_d = DONE;
                        rlvl_d  = lvl_q;
                        if (misaligned || ad_fault) begin
                            pte_d   = 32'h0;
                            fault_d = 1'b1;
                        end else begin
                            pte_d   = mem_data_i;
                            fault_d = 1'b0;
                        end
                    end else if (lvl_q == 2'd0) begin
                        // Pointer at the last level has nowhere to go.
                        state_d = DONE;
                        pte_d   = 32'h0;
                        rlvl_d  = 2'd0;
                        fault_d = 1'b1;
                    end else begin
                        base_d = {pte_ppn, 12'h000};
                        lvl_d  = lvl_q - 2'd1;
                    end
                end else if (flush_i) begin
                    abort_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            lvl_q   <= 2'd0;
            base_q  <= '0;
            vaddr_q <= '0;
            store_q <= 1'b0;
            abort_q <= 1'b0;
            pte_q   <= 32'h0;
            rlvl_q  <= 2'd0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lvl_q   <= lvl_d;
            base_q  <= base_d;
            vaddr_q <= vaddr_d;
            store_q <= store_d;
            abort_q <= abort_d;
            pte_q   <= pte_d;
            rlvl_q  <= rlvl_d;
            fault_q <= fault_d;
        end
    end

    assign resp_pte_o   = pte_q;
    assign resp_level_o = rlvl_q;
    assign resp_fault_o = fault_q;
    assign resp_vpn_o   = vaddr_q[VA_W-1:12];

endmodule

// File: tb/tb_mmu_ptw_gen.sv
// tb/tb_mmu_ptw_gen.sv - directed and randomized bench for mmu_ptw_gen
module tb_mmu_ptw_gen;

    localparam int LEVELS = 2;
    localparam int VPN_W  = 10;
    localparam int PPN_W  = 20;
    localparam int VA_W   = 32;
    localparam int PA_W   = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       satp;
    logic              req_valid;
    logic              req_ready;
    logic [VA_W-1:0]   req_vaddr;
    logic              req_store;
    logic              mem_req;
    logic [PA_W-1:0]   mem_addr;
    logic              mem_ack;
    logic [31:0]       mem_data;
    logic              mem_error;
    logic              resp_valid;
    logic [31:0]       resp_pte;
    logic [VA_W-13:0]  resp_vpn;
    logic [1:0]        resp_level;
    logic              resp_fault;
    logic              flush;
    logic              busy;

    always #5 clk = ~clk;

    mmu_ptw_gen #(.LEVELS(LEVELS), .VPN_W(VPN_W), .PPN_W(PPN_W)) dut (
        .clk_i(clk), .rst_i(rst), .satp_i(satp),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_vaddr_i(req_vaddr), .req_store_i(req_store),
        .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_ack_i(mem_ack),
        .mem_data_i(mem_data), .mem_error_i(mem_error),
        .resp_valid_o(resp_valid), .resp_pte_o(resp_pte), .resp_vpn_o(resp_vpn),
        .resp_level_o(resp_level), .resp_fault_o(resp_fault),
        .flush_i(flush), .busy_o(busy)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [logic [31:0]];

    logic [31:0] exp_addrs [$];
    logic [31:0] exp_pte;
    logic [1:0]  exp_lvl;
    logic        exp_fault;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    // Reference walk straight from the translation rules.
    task automatic model(input logic [31:0] va, input logic st, input int err_lvl);
        logic [31:0] base, a, pte, ppn, vpn;
        bit          done;
        exp_addrs.delete();
        exp_pte = 0; exp_lvl = 0; exp_fault = 0;
        if (!satp[31]) return;
        base = (satp & 32'h000F_FFFF) * 4096;
        done = 0;
        for (int l = LEVELS - 1; l >= 0 && !done; l--) begin
            vpn = (va >> (12 + l * VPN_W)) % (1 << VPN_W);
            a   = base + vpn * 4;
            exp_addrs.push_back(a);
            pte = rd(a);
            ppn = (pte >> 10) & 32'h000F_FFFF;
            exp_lvl = 2'(l);
            done = 1;
            if (l == err_lvl || !pte[0] || (pte[2] && !pte[1])) begin
                exp_fault = 1;
            end else if (pte[1] || pte[3]) begin
                if ((ppn % (1 << (l * VPN_W))) != 0) exp_fault = 1;
`ifdef MMU_PTW_AD_CHECK_EN
                else if (!pte[6] || (st && !pte[7])) exp_fault = 1;
`endif
                else exp_pte = pte;
            end else if (l == 0) begin
                exp_fault = 1;
            end else begin
                base = ppn * 4096;
                done = 0;
            end
        end
        if (st && 1'b0) exp_fault = 1;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic run_walk(input logic [31:0] va, input logic st, input int err_lvl);
        int waited;
        int d;
        model(va, st, err_lvl);
        check("ready_before_req", req_ready, 1);
        req_valid = 1; req_vaddr = va; req_store = st;
        tick();
        req_valid = 0;
        foreach (exp_addrs[k]) begin
            waited = 0;
            while (!mem_req && waited < 20) begin tick(); waited++; end
            check("mem_req", mem_req, 1);
            check("busy_walk", busy, 1);
            check("mem_addr", mem_addr, exp_addrs[k]);
            d = $urandom_range(0, 2);
            repeat (d) tick();
            check("mem_addr_hold", mem_addr, exp_addrs[k]);
            mem_ack   = 1;
            mem_data  = rd(exp_addrs[k]);
            mem_error = ((LEVELS - 1 - k) == err_lvl);
            tick();
            mem_ack = 0; mem_error = 0; mem_data = $urandom;
        end
        check("resp_valid", resp_valid, 1);
        check("resp_pte", resp_pte, exp_pte);
        check("resp_level", resp_level, exp_lvl);
        check("resp_fault", resp_fault, exp_fault);
        check("resp_vpn", resp_vpn, va >> 12);
        check("mem_req_done", mem_req, 0);
        tick();
        check("resp_valid_1cyc", resp_valid, 0);
        check("ready_after", req_ready, 1);
    endtask

    function automatic logic [31:0] rand_pte();
        logic [31:0] ppn, flags;
        ppn = $urandom & 32'h000F_FFFF;
        if ($urandom_range(0, 1) == 1) ppn = ppn & ~32'h3FF;
        case ($urandom_range(0, 6))
            0: flags = 32'h01;
            1: flags = 32'hCF;
            2: flags = 32'h0F;
            3: flags = 32'h4F;
            4: flags = 32'h05;
            5: flags = 32'h00;
            default: flags = $urandom & 32'h3FF;
        endcase
        return (ppn << 10) | flags;
    endfunction

    initial begin
        logic [31:0] va, p1, a0;
        int          err;

        rst = 1; satp = 32'h8000_0100; req_valid = 0; req_vaddr = 0; req_store = 0;
        mem_ack = 0; mem_data = 0; mem_error = 0; flush = 0;
        tick(); tick();
        check("rst_ready", req_ready, 1);
        check("rst_mem_req", mem_req, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_resp_pte", resp_pte, 0);
        check("rst_resp_fault", resp_fault, 0);
        check("rst_resp_level", resp_level, 0);
        check("rst_resp_vpn", resp_vpn, 0);
        check("rst_mem_addr", mem_addr, 0);
        rst = 0;
        tick();

        // two-level walk
        mem.delete();
        mem[32'h0010_0004] = 32'h0008_0001;
        mem[32'h0020_000C] = 32'h0012_34CF;
        run_walk(32'h0040_3000, 0, -1);

        // misaligned and aligned superpage
        mem[32'h0010_0004] = 32'h0000_04CF;
        run_walk(32'h0040_3000, 0, -1);
        mem[32'h0010_0004] = 32'h2000_00CF;
        run_walk(32'h0040_3000, 0, -1);

        // invalid PTE, bus error on L0
        mem[32'h0010_0004] = 32'h0;
        run_walk(32'h0040_3000, 0, -1);
        mem[32'h0010_0004] = 32'h0008_0001;
        run_walk(32'h0040_3000, 0, 0);

        // bypass, with flush held (ignored outside WALK)
        satp = 32'h0; flush = 1;
        run_walk(32'h1234_5000, 0, -1);
        satp = 32'h8000_0100; flush = 0;

        // A/D handling
        mem[32'h0010_0004] = 32'h0000_000F;
        run_walk(32'h0040_3000, 0, -1);
        mem[32'h0010_0004] = 32'h0000_004F;
        run_walk(32'h0040_3000, 1, -1);
        run_walk(32'h0040_3000, 0, -1);

        // flush while L1 pending, ack three cycles later
        mem[32'h0010_0004] = 32'h0008_0001;
        req_valid = 1; req_vaddr = 32'h0040_3000; req_store = 0;
        tick();
        req_valid = 0;
        check("flush_mem_req", mem_req, 1);
        flush = 1;
        tick();
        flush = 0;
        tick(); tick();
        check("flush_still_req", mem_req, 1);
        mem_ack = 1; mem_data = 32'h0008_0001;
        tick();
        mem_ack = 0;
        check("flush_no_resp", resp_valid, 0);
        check("flush_ready", req_ready, 1);
        check("flush_mem_req_off", mem_req, 0);
        tick();
        check("flush_no_resp2", resp_valid, 0);

        // flush coincident with ack
        req_valid = 1;
        tick();
        req_valid = 0;
        flush = 1; mem_ack = 1;
        tick();
        flush = 0; mem_ack = 0;
        check("flush_coinc_no_resp", resp_valid, 0);
        check("flush_coinc_ready", req_ready, 1);
        tick();
        check("flush_coinc_no_resp2", resp_valid, 0);

        // reset mid-walk, late ack ignored
        req_valid = 1;
        tick();
        req_valid = 0;
        rst = 1;
        tick();
        rst = 0;
        mem_ack = 1;
        tick();
        mem_ack = 0;
        check("rst_mid_no_resp", resp_valid, 0);
        check("rst_mid_ready", req_ready, 1);
        check("rst_mid_mem_req", mem_req, 0);
        tick();
        check("rst_mid_no_resp2", resp_valid, 0);

        // abort flag must not leak into the next walk
        mem[32'h0020_000C] = 32'h0012_34CF;
        run_walk(32'h0040_3000, 0, -1);

        // randomized tables
        for (int it = 0; it < 200; it++) begin
            mem.delete();
            va = $urandom;
            satp = ($urandom_range(0, 15) == 0) ? 32'h0000_0100 : 32'h8000_0100;
            p1 = rand_pte();
            mem[32'h0010_0000 + (va >> 22) * 4] = p1;
            if ($urandom_range(0, 1) == 1) p1 = (p1 & ~32'hF) | 32'h1;
            mem[32'h0010_0000 + (va >> 22) * 4] = p1;
            a0 = ((p1 >> 10) & 32'h000F_FFFF) * 4096 + ((va >> 12) % 1024) * 4;
            mem[a0] = rand_pte();
            err = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1)) : -1;
            run_walk(va, 1'($urandom_range(0, 1)), err);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
